// File: rtl/cfg_frame_loader.sv
// Serial bitstream to per-block config frames; drives shared bits bus and one-hot wr_en to latch blocks.
// Optional even-parity check per frame is enabled by defining CFG_FRAME_PARITY_EN.
module cfg_frame_loader #(
  parameter int NUM_BLK    = 4,
  parameter int BITS_W     = 18,
  parameter int STROBE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [BITS_W-1:0]  bits,
  output logic [NUM_BLK-1:0] wr_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

`ifdef CFG_FRAME_PARITY_EN
  localparam int FRAME_LEN = BITS_W + 1;
  localparam int SRW       = BITS_W;
`else
  localparam int FRAME_LEN = BITS_W;
  localparam int SRW       = BITS_W - 1;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int IW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

  logic [2:0]         state;
  logic [SRW-1:0]     shift_reg;
  logic [BITS_W-1:0]  shift_nxt;
  logic [BITS_W-1:0]  frame_dat;
  logic [CW-1:0]      cnt;
  logic [SW-1:0]      scnt;
  logic [IW-1:0]      idx;
  logic [NUM_BLK-1:0] onehot;
  logic               last_bit;
  logic               data_bit;
  logic               frame_bad;

  assign last_bit = (cnt == CW'(FRAME_LEN - 1));

`ifdef CFG_FRAME_PARITY_EN
  // The trailing parity bit is checked but never shifted into the data register.
  assign shift_nxt = {shift_reg[BITS_W-2:0], cfg_data};
  assign frame_dat = shift_reg;
  assign data_bit  = (cnt != CW'(BITS_W));
  assign frame_bad = ^{shift_reg, cfg_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (state == S_SHIFT && cfg_valid && last_bit && frame_bad) begin
      err <= 1'b1;
    end
  end
`else
  assign shift_nxt = {shift_reg, cfg_data};
  assign frame_dat = shift_nxt;
  assign data_bit  = 1'b1;
  assign frame_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_BLK; i++) onehot[i] = (idx == IW'(i));
  end

  assign cfg_ready = (state == S_SHIFT);
  assign busy      = (state != S_IDLE);

  // wr_en is a plain flop so asserting reset closes every latch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bits      <= '0;
      wr_en     <= '0;
      done      <= 1'b0;
      cnt       <= '0;
      scnt      <= '0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHIFT;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (cfg_valid) begin
            if (data_bit) shift_reg <= shift_nxt[SRW-1:0];
            if (last_bit) begin
              cnt   <= '0;
              bits  <= frame_dat;
              state <= frame_bad ? S_HOLD : S_SETUP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_SETUP: begin
          wr_en <= onehot;
          scnt  <= '0;
          state <= S_STROBE;
        end
        S_STROBE: begin
          if (scnt == SW'(STROBE_CYC - 1)) begin
            wr_en <= '0;
            state <= S_HOLD;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        S_HOLD: begin
          if (idx == IW'(NUM_BLK - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_SHIFT;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          wr_en <= '0;
        end
      endcase
    end
  end

endmodule
